// File: rtl/mac_seq.sv
// Sequencer for a 4-lane MAC wrapper: streams activation/weight groups into
// the MAC, chains the partial sum through c, and emits the final dot product.
module mac_seq #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [len_bw-1:0]    len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*bw-1:0]      in_a,
  input  logic [4*bw-1:0]      in_b,
  output logic [bw-1:0]        mac_a1,
  output logic [bw-1:0]        mac_a2,
  output logic [bw-1:0]        mac_a3,
  output logic [bw-1:0]        mac_a4,
  output logic [bw-1:0]        mac_b1,
  output logic [bw-1:0]        mac_b2,
  output logic [bw-1:0]        mac_b3,
  output logic [bw-1:0]        mac_b4,
  output logic [psum_bw-1:0]   mac_c,
  input  logic [psum_bw-1:0]   mac_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [psum_bw-1:0]   out_psum,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, ACCEPT, FEED, CAPTURE, DONE} state_t;

  state_t              state, state_nxt;
  logic [psum_bw-1:0]  acc;
  logic [len_bw-1:0]   cnt;
  logic [len_bw-1:0]   len_q;
  logic                last_group;

  // cnt counts captured groups, so the last capture happens at len_q-1.
  assign last_group = (cnt == len_q - len_bw'(1));

  assign in_ready  = (state == ACCEPT);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt takes a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCEPT;
      ACCEPT:  if (in_valid) state_nxt = FEED;
      FEED:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = last_group ? DONE : ACCEPT;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      mac_a1   <= '0;
      mac_a2   <= '0;
      mac_a3   <= '0;
      mac_a4   <= '0;
      mac_b1   <= '0;
      mac_b2   <= '0;
      mac_b3   <= '0;
      mac_b4   <= '0;
      mac_c    <= '0;
      out_psum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
            if (len == '0) out_psum <= '0;
            else           len_q    <= len;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            mac_a1 <= in_a[0*bw +: bw];
            mac_a2 <= in_a[1*bw +: bw];
            mac_a3 <= in_a[2*bw +: bw];
            mac_a4 <= in_a[3*bw +: bw];
            mac_b1 <= in_b[0*bw +: bw];
            mac_b2 <= in_b[1*bw +: bw];
            mac_b3 <= in_b[2*bw +: bw];
            mac_b4 <= in_b[3*bw +: bw];
            mac_c  <= acc;
          end
        end
        CAPTURE: begin
          acc <= mac_out;
          cnt <= cnt + len_bw'(1);
          // out_psum is loaded with the final sum so it is stable throughout DONE.
          if (last_group) out_psum <= mac_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Hardware sequencer that drives the 4-lane mac_wrapper, taking over the role the bench plays today.
- Accepts a stream of 4-lane activation/weight groups on a valid/ready input.
- For each group, presents the operands and the running psum as c to the MAC, then captures the MAC result back into an accumulator.
- After len groups, emits the final psum on a valid/ready output. Sits between the operand buffers and mac_wrapper.

Parameters:
- bw, 4, operand width; activations unsigned, weights two's-complement signed.
- psum_bw, 16, psum/accumulator width.
- len_bw, 8, width of the group-count input.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a dot-product job; sampled only in IDLE.
- len  in  len_bw  number of 4-lane groups in the job; captured on accepted start.
- in_valid  in  1  operand group valid.
- in_ready  out  1  block can accept a group.
- in_a  in  4*bw  activations; lane k = in_a[k*bw +: bw], lane 0 maps to a1.
- in_b  in  4*bw  weights; same lane packing, lane 0 maps to b1.
- mac_a1..mac_a4  out  bw each  registered activations to mac_wrapper.
- mac_b1..mac_b4  out  bw each  registered weights to mac_wrapper.
- mac_c  out  psum_bw  registered partial sum to mac_wrapper.
- mac_out  in  psum_bw  mac_wrapper result.
- out_valid  out  1  final psum valid.
- out_ready  in  1  consumer accepts psum.
- out_psum  out  psum_bw  final psum.
- busy  out  1  high in every state except IDLE.

Behaviour:
- MAC contract: mac_out = mac_c + sum(a_k unsigned * b_k signed) mod 2^psum_bw, valid exactly one cycle after the operands are stable on mac_*.
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - acc, cnt, len_q, all mac_* and out_psum are cleared to 0.
  - in_ready, out_valid and busy are cleared to 0.
  - Reset mid-job abandons the job; no output is produced.
- States: IDLE, ACCEPT, FEED, CAPTURE, DONE.
  - IDLE:
    - start=1 with len!=0: len_q<=len, acc<=0, cnt<=0, go to ACCEPT.
    - start=1 with len==0: acc<=0, go to DONE.
  - ACCEPT:
    - in_ready=1 (combinational from state).
    - On in_valid=1: register the 4 lanes into mac_a*/mac_b*, mac_c<=acc, go to FEED.
    - Otherwise hold; mac_* keep their values.
  - FEED: in_ready=0; the wrapper samples operands; unconditionally go to CAPTURE.
  - CAPTURE:
    - acc<=mac_out, cnt<=cnt+1.
    - If cnt==len_q-1, go to DONE; else go to ACCEPT.
  - DONE:
    - out_valid=1, out_psum=acc (registered, stable while waiting).
    - On out_ready=1: go to IDLE next cycle, out_valid drops.
- Throughput:
  - Max one group per 3 cycles.
  - Latency from the accepting in_valid of the last group to out_valid is 3 cycles.
- Arithmetic: accumulation wraps mod 2^psum_bw; no saturation, no overflow flag.
- start while busy is ignored; len changes after capture are ignored.
- in_valid outside ACCEPT is ignored; no data is consumed.
- out_ready outside DONE has no effect.
- len=2^len_bw-1 (255) is legal; cnt is len_bw wide and never wraps within a job.

Test Plan:
- Single group: start, len=1; a=(1,2,3,4), b=(1,-1,2,-2) -> mac_c=0 during FEED; out_valid 3 cycles after accept; out_psum=0xFFFD (-3).
- Two groups chained: first group as in the single-group test, then a=(15,15,15,15), b=(-8,-8,-8,-8) -> mac_c=0xFFFD on the 2nd FEED; out_psum=0xFE1D (-483).
- Back-pressure:
  - in_valid held low 3 cycles in ACCEPT -> in_ready stays 1, mac_* unchanged, no cnt advance.
  - out_ready held low 4 cycles in DONE -> out_valid/out_psum held constant; start pulses in this window are ignored.
- len=0 -> out_valid in the cycle after start with out_psum=0; in_ready never asserted.
- Wrap: len=255, every group a=15, b=-8 -> out_psum=0x21E0 (-122400 mod 65536).
- Reset mid-job: reset_n low during FEED of group 2 of 3 -> all outputs 0 immediately; a new job with len=1 afterwards gives correct psum with no residue.
